pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
Program-counter register with next-PC selection for the single-issue RISC-V core. Each cycle it chooses the sequential path (pc+INSTR_BYTES), a branch target (pc+offset) or a JALR target ((base+imm)&~1). It holds the PC on stall and buffers one redirect that arrives during a stall. A misaligned target redirects the PC to a trap vector and records the faulting address.

Parameters:
DATA_WIDTH, 32, width of PC and all address operands (from defs.vh)
RESET_VECTOR, 32'h0000_0000, PC value after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned target
INSTR_BYTES, 4, sequential increment
ALLOW_COMPRESSED, 0, 0: targets must be 4-byte aligned; 1: targets must be 2-byte aligned

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC; redirects are buffered, not applied
branch_taken  in  1  take pc+offset this cycle
offset  in  DATA_WIDTH  signed branch/JAL offset, two's complement
jalr_en  in  1  take JALR target this cycle
jalr_base  in  DATA_WIDTH  rs1 value
jalr_imm  in  DATA_WIDTH  sign-extended I-immediate
pc  out  DATA_WIDTH  current PC (registered)
pc_plus  out  DATA_WIDTH  pc+INSTR_BYTES (combinational from pc)
redirect_pending  out  1  a buffered redirect is waiting for stall to drop
misaligned  out  1  one-cycle pulse, PC was just loaded with TRAP_VECTOR
bad_addr  out  DATA_WIDTH  last misaligned target (sticky until next fault or reset)

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_VECTOR, redirect_pending=0, misaligned=0, bad_addr=0. rst overrides every other input.
- Target calculation: all arithmetic is modulo 2^DATA_WIDTH with wrap and no overflow flag.
  - br_tgt = pc+offset.
  - jr_tgt = (jalr_base+jalr_imm) with bit0 forced to 0.
- Priority when not stalled: pending redirect > jalr_en > branch_taken > sequential. If jalr_en and branch_taken are both high, JALR wins.
- Alignment check applies to the selected redirect target only. The sequential path is never checked.
  - Misaligned when tgt[1]!=0 with ALLOW_COMPRESSED=0, or tgt[0]!=0 with ALLOW_COMPRESSED=1.
  - JALR with ALLOW_COMPRESSED=1 can never fault, because bit0 is already cleared.
- Misaligned target: next pc=TRAP_VECTOR, misaligned=1 for exactly that cycle, bad_addr=tgt. The fault is evaluated when the target is applied to the PC, not when it is buffered.
- Stall=1:
  - pc holds and misaligned=0.
  - If jalr_en or branch_taken is high, the computed target (from the current pc and inputs) is latched into the pending register and redirect_pending=1.
  - A later redirect during the same stall overwrites the pending target (newest wins).
- Stall falls to 0 with redirect_pending=1: on the next edge pc loads the pending target (with the alignment check) and redirect_pending clears. Any jalr_en/branch_taken present in that same cycle is ignored.
- Latency: one cycle from a redirect input (unstalled) to the new pc value.
- Reset mid-stall discards the pending redirect.
- Wrap-around: pc=32'hFFFF_FFFC, sequential → pc=0.

Decomposition:
- Add to defs.vh: PC_SEL_SEQ=2'd0, PC_SEL_BR=2'd1, PC_SEL_JALR=2'd2, PC_SEL_PEND=2'd3; also RESET_VECTOR and TRAP_VECTOR defaults.
- One combinational sub-module, pc_target_calc, computes br_tgt, jr_tgt, pc_plus and the misalignment flag.
- The top level holds the pc register, pending register, select FSM (IDLE/PENDING) and fault registers.

Test Plan:
- rst=1 for 2 cycles, then release with no redirects → pc=0, 4, 8, 12 on successive cycles; misaligned=0, bad_addr=0.
- pc=16, branch_taken=1, offset=-8 → next pc=8; offset=32'd10 from pc=8 → pc=TRAP_VECTOR (0x100), misaligned pulses 1 cycle, bad_addr=18.
- jalr_en=1, base=0x203, imm=1 → pc=0x204 (bit0 cleared); same cycle with branch_taken=1 → JALR still wins.
- Hold stall=1 for 3 cycles while branch (pc=40, offset=24) then JALR (base=0x80, imm=0) arrive → pc holds 40, redirect_pending=1; stall drops → pc=0x80, pending clears.
- Pending redirect present, rst pulsed during stall → pc=RESET_VECTOR, redirect_pending=0; no redirect is applied after stall drops.
- pc=0xFFFF_FFFC sequential → pc=0. With ALLOW_COMPRESSED=1, branch from 0 with offset=2 → pc=2 and no fault.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared types, widths and reset/trap defaults for the program-counter unit.
package pc_next_unit_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [DATA_WIDTH-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [DATA_WIDTH-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
    localparam int unsigned           INSTR_BYTES_DEF  = 4;

    // Next-PC source select
    typedef enum logic [1:0] {
        PC_SEL_SEQ  = 2'd0,
        PC_SEL_BR   = 2'd1,
        PC_SEL_JALR = 2'd2,
        PC_SEL_PEND = 2'd3
    } pc_sel_e;

    // Redirect buffering state
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } pc_state_e;

    // Compressed mode only needs halfword alignment; otherwise only bit1 is checked.
    function automatic logic is_misaligned(input logic [DATA_WIDTH-1:0] tgt,
                                           input logic                  allow_compressed);
        return allow_compressed ? tgt[0] : tgt[1];
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Redirect request inputs and PC/fault outputs of the program-counter unit.
interface pc_next_unit_if;
    import pc_next_unit_pkg::*;

    logic                  stall;
    logic                  branch_taken;
    logic [DATA_WIDTH-1:0] offset;
    logic                  jalr_en;
    logic [DATA_WIDTH-1:0] jalr_base;
    logic [DATA_WIDTH-1:0] jalr_imm;

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus;
    logic                  redirect_pending;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] bad_addr;

    modport master (
        output stall, branch_taken, offset, jalr_en, jalr_base, jalr_imm,
        input  pc, pc_plus, redirect_pending, misaligned, bad_addr
    );

    modport slave (
        input  stall, branch_taken, offset, jalr_en, jalr_base, jalr_imm,
        output pc, pc_plus, redirect_pending, misaligned, bad_addr
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational target arithmetic: sequential, branch and JALR targets, the
// selected redirect target and its alignment fault flag.
module pc_target_calc
    import pc_next_unit_pkg::*;
#(
    parameter int unsigned INSTR_BYTES      = INSTR_BYTES_DEF,
    parameter int unsigned ALLOW_COMPRESSED = 0
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0] jalr_base,
    input  logic [DATA_WIDTH-1:0] jalr_imm,
    input  logic [DATA_WIDTH-1:0] pend_tgt,
    input  pc_sel_e               sel,
    output logic [DATA_WIDTH-1:0] pc_plus,
    output logic [DATA_WIDTH-1:0] br_tgt,
    output logic [DATA_WIDTH-1:0] jr_tgt,
    output logic [DATA_WIDTH-1:0] sel_tgt,
    output logic                  tgt_misaligned
);

    logic [DATA_WIDTH-1:0] jr_sum;

    // All sums wrap modulo 2^DATA_WIDTH
    always_comb begin
        pc_plus = pc + DATA_WIDTH'(INSTR_BYTES);
        br_tgt  = pc + offset;
        jr_sum  = jalr_base + jalr_imm;
        jr_tgt  = {jr_sum[DATA_WIDTH-1:1], 1'b0};
    end

    always_comb begin
        sel_tgt = pc_plus;
        case (sel)
            PC_SEL_BR:   sel_tgt = br_tgt;
            PC_SEL_JALR: sel_tgt = jr_tgt;
            PC_SEL_PEND: sel_tgt = pend_tgt;
            default:     sel_tgt = pc_plus;
        endcase
    end

    // The sequential path is never checked for alignment
    always_comb begin
        tgt_misaligned = 1'b0;
        if (sel != PC_SEL_SEQ) begin
            tgt_misaligned = is_misaligned(sel_tgt, ALLOW_COMPRESSED != 0);
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register with next-PC selection, stall-time redirect
// buffering and misaligned-target trapping.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR     = RESET_VECTOR_DEF,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR      = TRAP_VECTOR_DEF,
    parameter int unsigned           INSTR_BYTES      = INSTR_BYTES_DEF,
    parameter int unsigned           ALLOW_COMPRESSED = 0
) (
    input  logic           clk,
    input  logic           rst,
    pc_next_unit_if.slave  bus
);

    pc_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic                  mis_q, mis_d;
    logic [DATA_WIDTH-1:0] bad_q, bad_d;

    pc_sel_e               sel;
    logic [DATA_WIDTH-1:0] pc_plus;
    logic [DATA_WIDTH-1:0] br_tgt;
    logic [DATA_WIDTH-1:0] jr_tgt;
    logic [DATA_WIDTH-1:0] sel_tgt;
    logic                  tgt_misaligned;

    pc_target_calc #(
        .INSTR_BYTES      (INSTR_BYTES),
        .ALLOW_COMPRESSED (ALLOW_COMPRESSED)
    ) u_calc (
        .pc             (pc_q),
        .offset         (bus.offset),
        .jalr_base      (bus.jalr_base),
        .jalr_imm       (bus.jalr_imm),
        .pend_tgt       (pend_tgt_q),
        .sel            (sel),
        .pc_plus        (pc_plus),
        .br_tgt         (br_tgt),
        .jr_tgt         (jr_tgt),
        .sel_tgt        (sel_tgt),
        .tgt_misaligned (tgt_misaligned)
    );

    // Source priority when running: pending > JALR > branch > sequential
    always_comb begin
        sel = PC_SEL_SEQ;
        if (!bus.stall) begin
            if (state_q == ST_PENDING) begin
                sel = PC_SEL_PEND;
            end else if (bus.jalr_en) begin
                sel = PC_SEL_JALR;
            end else if (bus.branch_taken) begin
                sel = PC_SEL_BR;
            end
        end
    end

    // Next-state: buffer redirects while stalled, apply one target otherwise
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        mis_d      = 1'b0;
        bad_d      = bad_q;

        if (bus.stall) begin
            if (bus.jalr_en) begin
                pend_tgt_d = jr_tgt;
                state_d    = ST_PENDING;
            end else if (bus.branch_taken) begin
                pend_tgt_d = br_tgt;
                state_d    = ST_PENDING;
            end
        end else begin
            state_d = ST_IDLE;
            if (sel == PC_SEL_SEQ) begin
                pc_d = pc_plus;
            end else if (tgt_misaligned) begin
                pc_d  = TRAP_VECTOR;
                mis_d = 1'b1;
                bad_d = sel_tgt;
            end else begin
                pc_d = sel_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            pend_tgt_q <= '0;
            mis_q      <= 1'b0;
            bad_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            mis_q      <= mis_d;
            bad_q      <= bad_d;
        end
    end

    assign bus.pc               = pc_q;
    assign bus.pc_plus          = pc_plus;
    assign bus.redirect_pending = (state_q == ST_PENDING);
    assign bus.misaligned       = mis_q;
    assign bus.bad_addr         = bad_q;

endmodule
